mpp_prog_mem: RTL and testbench

Program-memory responder for the `mpp` core's instruction-fetch interface. It serves bytes on `instruction` when the core requests them via the fetch strobe (`out_signals[1]`) and `program_addr`. It also provides a byte-stream loader so a host can write a program image before releasing the core. It sits between the core and the host/boot logic, and replaces the behavioural fetch model used in simulation.

---
 rtl/mpp_pkg.sv | 16 +
 rtl/mpp_prog_ram.sv | 24 ++
 rtl/mpp_prog_mem.sv | 137 +++++++++++++
 tb/tb_mpp_prog_mem.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mpp_pkg.sv
// mpp_pkg: shared definitions for the mpp core and its program memory.
//   state_t      - program-memory controller states (CLEAR/RUN/LOAD)
//   MPP_NOP      - mpp NOP opcode, used as the default memory fill
//   PROG_ADDR_W  - width of the core's program address bus
package mpp_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_t;

    localparam logic [7:0] MPP_NOP     = 8'h00;
    localparam int         PROG_ADDR_W = 16;

endpackage

// File: rtl/mpp_prog_ram.sv
// mpp_prog_ram: single-port synchronous byte RAM, 2^ADDR_WIDTH deep.
//   clk   - clock
//   we    - write enable; wdata is written at addr
//   addr  - port address (shared by read and write)
//   wdata - write byte
//   rdata - registered read of addr, available the cycle after
module mpp_prog_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mpp_prog_mem.sv
// mpp_prog_mem: program memory for the mpp instruction-fetch port, with a
// host byte-stream loader. Clears itself to FILL after reset.
//   clk, rst          - clock, synchronous active-high reset
//   fetch_en          - fetch strobe from the core
//   program_addr      - fetch address from the core
//   instruction       - fetched byte (1-cycle latency, held between fetches)
//   instr_valid       - pulse: instruction updated by a served fetch
//   cpu_hold          - memory busy (clearing or loading)
//   addr_fault        - sticky: a fetch addressed beyond the implemented depth
//   load_start        - begin a load at address 0
//   load_valid/data   - program byte stream
//   load_ready        - a byte offered this cycle will be written
//   load_end          - finish the load
//   load_count        - bytes written by the current/last load
//   load_ovf          - sticky until next load_start: byte offered while full
module mpp_prog_mem
    import mpp_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] FILL       = MPP_NOP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic [PROG_ADDR_W-1:0] program_addr,
    output logic [7:0]             instruction,
    output logic                   instr_valid,
    output logic                   cpu_hold,
    output logic                   addr_fault,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [7:0]             load_data,
    output logic                   load_ready,
    input  logic                   load_end,
    output logic [ADDR_WIDTH:0]    load_count,
    output logic                   load_ovf
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  oob;
    logic                  oob_q;
    logic [7:0]            instr_hold;
    logic                  load_accept;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;

    // Shift of 16-bit address yields zero when ADDR_WIDTH covers the full bus.
    assign oob         = (program_addr >> ADDR_WIDTH) != '0;
    assign cpu_hold    = (state != ST_RUN);
    assign load_ready  = (state == ST_LOAD) && (load_count < DEPTH);
    assign load_accept = load_valid && load_ready;

    // RAM rdata moves every cycle, so the last served byte is kept in
    // instr_hold and presented whenever no new fetch result is due.
    assign instruction = instr_valid ? (oob_q ? FILL : ram_rdata) : instr_hold;

    // Reads only happen in RUN and writes only in CLEAR/LOAD, so one port does.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = program_addr[ADDR_WIDTH-1:0];
        ram_wdata = FILL;
        case (state)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_ptr;
            end
            ST_LOAD: begin
                ram_we    = load_accept;
                ram_addr  = wr_ptr;
                ram_wdata = load_data;
            end
            default: ;
        endcase
    end

    mpp_prog_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            load_count  <= '0;
            load_ovf    <= 1'b0;
            addr_fault  <= 1'b0;
            instr_valid <= 1'b0;
            oob_q       <= 1'b0;
            instr_hold  <= FILL;
        end else begin
            instr_valid <= 1'b0;
            if (instr_valid) instr_hold <= instruction;
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fetch_en) begin
                        instr_valid <= 1'b1;
                        oob_q       <= oob;
                        if (oob) addr_fault <= 1'b1;
                    end
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_ptr     <= '0;
                        load_count <= '0;
                        load_ovf   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_accept) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        load_count <= load_count + 1'b1;
                    end
                    if (load_valid && !load_ready) load_ovf <= 1'b1;
                    if (load_end) state <= ST_RUN;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mpp_prog_mem.sv
// tb_mpp_prog_mem: directed bench for mpp_prog_mem with a 16-byte memory
// (ADDR_WIDTH=4) so that a full load and an overflow stay short.
module tb_mpp_prog_mem;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic [15:0]   program_addr = '0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_data = '0;
    logic          load_end = 1'b0;
    logic [7:0]    instruction;
    logic          instr_valid;
    logic          cpu_hold;
    logic          addr_fault;
    logic          load_ready;
    logic [AW:0]   load_count;
    logic          load_ovf;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mpp_prog_mem #(.ADDR_WIDTH(AW), .FILL(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .program_addr (program_addr),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .cpu_hold     (cpu_hold),
        .addr_fault   (addr_fault),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_end     (load_end),
        .load_count   (load_count),
        .load_ovf     (load_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one fetch cycle; callers chain these for back-to-back fetches.
    task automatic fetch(input logic [15:0] a, input logic [7:0] exp, input string tag);
        fetch_en     = 1'b1;
        program_addr = a;
        step();
        fetch_en     = 1'b0;
        check({tag, "_vld"}, instr_valid, 1);
        check(tag, instruction, exp);
    endtask

    task automatic load_byte(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] img [5];
        img = '{8'h07, 8'hC1, 8'h66, 8'h07, 8'h03};

        // Reset values
        step();
        check("rst_hold",   cpu_hold,    1);
        check("rst_valid",  instr_valid, 0);
        check("rst_instr",  instruction, 8'h00);
        check("rst_fault",  addr_fault,  0);
        check("rst_ready",  load_ready,  0);
        check("rst_count",  load_count,  0);
        check("rst_ovf",    load_ovf,    0);
        rst = 1'b0;

        // CLEAR lasts exactly 16 cycles
        n = 0;
        while (cpu_hold && n < 100) begin
            step();
            n++;
        end
        check("clear_cycles", n, 16);
        for (int i = 0; i < 6; i++) fetch(16'(i), 8'h00, "clr_fetch");

        // Load 5 bytes and read them back
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load_hold",  cpu_hold,   1);
        check("load_ready", load_ready, 1);
        check("load_cnt0",  load_count, 0);
        for (int i = 0; i < 5; i++) load_byte(img[i]);
        check("load_cnt5", load_count, 5);
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        check("end_hold", cpu_hold, 0);
        for (int i = 0; i < 5; i++) fetch(16'(i), img[i], "img_fetch");
        fetch(16'd5, 8'h00, "img_fetch5");
        fetch(16'd1, 8'hC1, "img_fetch1");
        step();
        check("idle_valid", instr_valid, 0);
        check("idle_instr", instruction, 8'hC1);

        // Out-of-range fetches
        fetch(16'h0010, 8'h00, "oob10");
        check("fault_set", addr_fault, 1);
        fetch(16'h0100, 8'h00, "oob100");
        fetch(16'h0002, 8'h66, "after_oob");
        check("fault_sticky", addr_fault, 1);

        // Fetch during LOAD, byte accepted with load_end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        fetch_en     = 1'b1;
        program_addr = 16'h0000;
        load_valid   = 1'b1;
        load_data    = 8'hAA;
        step();
        check("ld_fetch_hold",  cpu_hold,    1);
        check("ld_fetch_valid", instr_valid, 0);
        check("ld_fetch_instr", instruction, 8'h66);
        check("ld_fetch_cnt",   load_count,  1);
        load_data = 8'hBB;
        load_end  = 1'b1;
        step();
        load_end   = 1'b0;
        load_valid = 1'b0;
        check("ret_hold",  cpu_hold,    0);
        check("ret_valid", instr_valid, 0);
        check("ret_cnt",   load_count,  2);
        fetch(16'd0, 8'hAA, "ret_f0");
        fetch(16'd1, 8'hBB, "ret_f1");
        fetch(16'd2, 8'h66, "ret_f2_kept");

        // Full load plus one overflow byte
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) load_byte(8'h10 + 8'(i));
        check("full_cnt",   load_count, 16);
        check("full_ready", load_ready, 0);
        check("full_ovf0",  load_ovf,   0);
        load_byte(8'hEE);
        check("ovf_set", load_ovf,   1);
        check("ovf_cnt", load_count, 16);
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        fetch(16'd0,  8'h10, "full_f0");
        fetch(16'd15, 8'h1F, "full_f15");
        check("ovf_sticky", load_ovf, 1);

        // Reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ovf_cleared", load_ovf, 0);
        for (int i = 0; i < 3; i++) load_byte(8'h01 + 8'(i));
        check("mid_cnt", load_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_hold",  cpu_hold,   1);
        check("mid_rst_cnt",   load_count, 0);
        check("mid_rst_fault", addr_fault, 0);
        n = 0;
        while (cpu_hold && n < 100) begin
            step();
            n++;
        end
        check("reclear_cycles", n, 16);
        for (int i = 0; i < 16; i++) fetch(16'(i), 8'h00, "reclear_fetch");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
